mem_access_unit: RTL
====================

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255: maximum number of WAIT cycles before a load is aborted.
REQ-002 SHALL have one clock and an asynchronous active-low reset, as follows:
- clk  in  1  sole clock; all flops rising-edge.
- reset  in  1  asynchronous, active-low.
REQ-003 SHALL have these pipeline-side ports:
- MemReqM  in  1  M-stage instruction is a load or store.
- MemWriteM  in  1  1 = store, 0 = load.
- ALUOutM  in  32  byte address.
- WriteDataM  in  32  pre-shifted store data.
- MaskM  in  4  store byte enables, bit 3 = byte at offset 0 (big-endian).
- LBLHEnableM  in  2  load size: 00 word, 01 half, 10 byte; 11 treated as word.
- SignExtM  in  1  sign-extend sub-word loads.
- ReadDataM  out  32  aligned and extended load result.
- StallM  out  1  freeze the I/X/M pipeline registers.
- ErrM  out  1  one-cycle pulse on misaligned access or timeout.
REQ-004 SHALL have these memory-side ports:
- mem_req_valid  out  1  request valid.
- mem_req_ready  in  1  memory accepts the request.
- mem_addr  out  32  word address, bits [1:0] = 00.
- mem_we  out  1  write request.
- mem_be  out  4  byte enables.
- mem_wdata  out  32  write data.
- mem_resp_valid  in  1  load data valid.
- mem_rdata  in  32  load data.

Function
REQ-005 SHALL implement the FSM states IDLE, REQ, WAIT and DONE.
REQ-006 IDLE with MemReqM=1 SHALL assert StallM combinationally in the same cycle, latch the address, data, mask, size and sign inputs, and go to REQ; if the access is misaligned it SHALL go to DONE with the error flag set instead.
REQ-007 Misaligned SHALL mean a word load with ALUOutM[1:0]!=00 or a half load with ALUOutM[0]=1; a misaligned access SHALL issue no memory request.
REQ-008 REQ SHALL drive mem_req_valid=1 with the latched mem_addr, mem_we, mem_be and mem_wdata held stable until mem_req_ready=1.
REQ-009 On the REQ handshake, a store SHALL go to DONE and a load SHALL go to WAIT.
REQ-010 mem_be SHALL equal the latched MaskM for stores and 4'b0000 for loads.
REQ-011 WAIT SHALL count cycles; on mem_resp_valid=1 it SHALL register the formatted data and go to DONE.
REQ-012 If the WAIT count reaches TIMEOUT_CYCLES with no response, the block SHALL set the error flag, force the data to 0, and go to DONE.
REQ-013 A response arriving in the same cycle as the timeout SHALL win (no error).
REQ-014 DONE SHALL hold StallM=0, present ReadDataM, pulse ErrM if the error flag is set, and go to IDLE unconditionally.
REQ-015 StallM SHALL be 1 in REQ and WAIT, and in IDLE when MemReqM=1; it SHALL be 0 otherwise.
REQ-016 A back-to-back access SHALL be accepted in the IDLE cycle following DONE; minimum latency is 3 cycles for a store and 4 for a load (IDLE→REQ→WAIT→DONE, with ready and response each arriving the cycle after being awaited).
REQ-017 Load formatting SHALL be big-endian:
- Byte at offset k SHALL be rdata[31-8k:24-8k].
- Half at offset 0 SHALL be [31:16]; at offset 2, [15:0].
- Sub-word results SHALL be zero- or sign-extended to 32 bits per SignExtM.
REQ-018 ReadDataM SHALL be held from DONE until the next load's DONE; stores and errored accesses SHALL NOT alter it, except that an error forces it to 0.
REQ-019 mem_resp_valid outside WAIT SHALL be ignored.
REQ-020 The timeout counter SHALL be sized $clog2(TIMEOUT_CYCLES+1) bits and SHALL clear on entry to WAIT.

Reset
REQ-021 Asserting reset low SHALL immediately force state IDLE, mem_req_valid=0, ErrM=0, ReadDataM=0, the counter to 0 and all latches to 0, including mid-REQ or mid-WAIT.
REQ-022 After reset, StallM SHALL follow MemReqM combinationally; a response to an aborted request SHALL be ignored per REQ-019.

Structure
REQ-023 The state encoding and load-size codes (WORD, HALF, BYTE) SHALL live in the shared package mips_pkg.
REQ-024 Load alignment and extension SHALL be one combinational sub-module, load_align (inputs: rdata, offset, size, sign; output: 32-bit data).

Verification
REQ-025 Word load at 0x100, ready on the first REQ cycle, response mem_rdata=0xDEADBEEF after 2 WAIT cycles → StallM high for 4 cycles, ReadDataM=0xDEADBEEF in DONE, ErrM=0.
REQ-026 Byte load at 0x103 with SignExtM=1 and mem_rdata=0x123456F0 → ReadDataM=0xFFFFFFF0; the same access with SignExtM=0 → 0x000000F0.
REQ-027 Store at 0x202, MaskM=0011, WriteDataM=0x0000ABCD, mem_req_ready held low 3 cycles → mem_addr=0x200, mem_be=0011, stable request for 4 cycles, then DONE, ReadDataM unchanged.
REQ-028 Half load at 0x101 → no mem_req_valid, ErrM pulses in the cycle after the request, ReadDataM=0.
REQ-029 Load with TIMEOUT_CYCLES=4 and no response → ErrM after 4 WAIT cycles, ReadDataM=0; a second run with the response in the 4th WAIT cycle → no error.
REQ-030 Reset asserted in WAIT, then a late mem_resp_valid → state IDLE, mem_req_valid=0 asynchronously, response ignored, next load completes normally.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared types for the memory access unit: FSM state encoding
// and load-size codes driven by the decode stage.
package mips_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_REQ  = 2'b01,
        S_WAIT = 2'b10,
        S_DONE = 2'b11
    } state_e;

    localparam logic [1:0] WORD = 2'b00;
    localparam logic [1:0] HALF = 2'b01;
    localparam logic [1:0] BYTE = 2'b10;

endpackage

// File: rtl/load_align.sv
// Big-endian load alignment: picks the addressed byte/half out of
// the memory word and zero- or sign-extends it to 32 bits.
module load_align
    import mips_pkg::*;
(
    input  logic [31:0] rdata_i,
    input  logic [1:0]  offset_i,
    input  logic [1:0]  size_i,
    input  logic        sign_i,
    output logic [31:0] data_o
);

    logic [15:0] half_v;
    logic [7:0]  byte_v;

    always_comb begin
        half_v = offset_i[1] ? rdata_i[15:0] : rdata_i[31:16];
        unique case (offset_i)
            2'd0: byte_v = rdata_i[31:24];
            2'd1: byte_v = rdata_i[23:16];
            2'd2: byte_v = rdata_i[15:8];
            2'd3: byte_v = rdata_i[7:0];
        endcase
        // size 11 falls through to a full word
        case (size_i)
            HALF:    data_o = {{16{sign_i & half_v[15]}}, half_v};
            BYTE:    data_o = {{24{sign_i & byte_v[7]}}, byte_v};
            default: data_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// M-stage load/store sequencer: valid/ready request, load response
// wait with timeout, big-endian formatting and error pulse.
module mem_access_unit
    import mips_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemReqM,
    input  logic        MemWriteM,
    input  logic [31:0] ALUOutM,
    input  logic [31:0] WriteDataM,
    input  logic [3:0]  MaskM,
    input  logic [1:0]  LBLHEnableM,
    input  logic        SignExtM,
    output logic [31:0] ReadDataM,
    output logic        StallM,
    output logic        ErrM,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic [31:0] mem_addr,
    output logic        mem_we,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_resp_valid,
    input  logic [31:0] mem_rdata
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT_CYCLES);

    state_e        state_q, state_d;
    logic [31:0]   addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [31:0]   rdata_q, rdata_d;
    logic [3:0]    mask_q, mask_d;
    logic [1:0]    size_q, size_d;
    logic          sign_q, sign_d;
    logic          we_q, we_d;
    logic          err_q, err_d;
    logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
    logic          is_word, misaligned;
    logic [31:0]   load_data;

    assign is_word = (LBLHEnableM == WORD) || (LBLHEnableM == 2'b11);
    assign misaligned = !MemWriteM &&
        ((is_word && (ALUOutM[1:0] != 2'b00)) ||
         ((LBLHEnableM == HALF) && ALUOutM[0]));
    assign cnt_inc = cnt_q + CW'(1);

    load_align u_align (
        .rdata_i  (mem_rdata),
        .offset_i (addr_q[1:0]),
        .size_i   (size_q),
        .sign_i   (sign_q),
        .data_o   (load_data)
    );

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        mask_d  = mask_q;
        size_d  = size_q;
        sign_d  = sign_q;
        we_d    = we_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            S_IDLE: begin
                if (MemReqM) begin
                    addr_d  = ALUOutM;
                    wdata_d = WriteDataM;
                    mask_d  = MaskM;
                    size_d  = LBLHEnableM;
                    sign_d  = SignExtM;
                    we_d    = MemWriteM;
                    err_d   = misaligned;
                    if (misaligned) begin
                        rdata_d = '0;
                        state_d = S_DONE;
                    end else begin
                        state_d = S_REQ;
                    end
                end
            end
            S_REQ: begin
                if (mem_req_ready) begin
                    cnt_d   = '0;
                    state_d = we_q ? S_DONE : S_WAIT;
                end
            end
            S_WAIT: begin
                // a response in the timeout cycle still wins
                if (mem_resp_valid) begin
                    rdata_d = load_data;
                    state_d = S_DONE;
                end else if (cnt_inc == CNT_MAX) begin
                    err_d   = 1'b1;
                    rdata_d = '0;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            S_DONE: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            mask_q  <= '0;
            size_q  <= '0;
            sign_q  <= 1'b0;
            we_q    <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            mask_q  <= mask_d;
            size_q  <= size_d;
            sign_q  <= sign_d;
            we_q    <= we_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    assign StallM = (state_q == S_REQ) || (state_q == S_WAIT) ||
                    ((state_q == S_IDLE) && MemReqM);
    assign ErrM          = (state_q == S_DONE) && err_q;
    assign ReadDataM     = rdata_q;
    assign mem_req_valid = (state_q == S_REQ);
    assign mem_addr      = {addr_q[31:2], 2'b00};
    assign mem_we        = we_q;
    assign mem_be        = we_q ? mask_q : 4'b0000;
    assign mem_wdata     = wdata_q;

endmodule
